dca_matrix_move_controller: RTL

DCA_MATRIX_MOVE_CONTROLLER -- requirements
Module: dca_matrix_move_controller

---
 rtl/dca_matrix_move_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dca_matrix_move_controller.sv
// Row-stream <-> matrix shift-register move controller.
// Loads rows (with optional zero padding) into the matrix or unloads the matrix through a skid-free output register.
module dca_matrix_move_controller #(
   parameter int MATRIX_SIZE_PARA = 8,
   parameter int BW_TENSOR_SCALAR = 32,
   localparam int NUM_ROW = MATRIX_SIZE_PARA,
   localparam int BW_TENSOR_ROW = MATRIX_SIZE_PARA*BW_TENSOR_SCALAR,
   localparam int BW_ROW_CNT = $clog2(NUM_ROW+1)
) (
   input  logic                     clk,
   input  logic                     rstnn,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [BW_ROW_CNT-1:0]    cmd_num_row,
   input  logic                     cmd_align,
   output logic                     busy,
   output logic                     done,
   input  logic                     sin_valid,
   output logic                     sin_ready,
   input  logic [BW_TENSOR_ROW-1:0] sin_data,
   output logic                     sout_valid,
   input  logic                     sout_ready,
   output logic [BW_TENSOR_ROW-1:0] sout_data,
   output logic                     move_wenable,
   output logic [BW_TENSOR_ROW-1:0] move_wdata_list,
   output logic                     move_renable,
   input  logic [BW_TENSOR_ROW-1:0] move_rdata_list
);

   localparam logic [BW_ROW_CNT-1:0] NUM_ROW_CNT = BW_ROW_CNT'(NUM_ROW);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PAD,
      UNLOAD,
      DRAIN,
      DONE
   } state_t;

   state_t                     state_reg;
   logic [BW_ROW_CNT-1:0]      row_cnt_reg;
   logic [BW_ROW_CNT-1:0]      num_row_reg;
   logic                       align_reg;
   logic                       sout_valid_reg;
   logic [BW_TENSOR_ROW-1:0]   sout_data_reg;

   logic [BW_ROW_CNT-1:0]      eff_num_row;
   logic                       last_row;
   logic                       load_fire;

   // Zero or out-of-range requests mean "the whole matrix".
   assign eff_num_row = ((cmd_num_row == '0) || (cmd_num_row > NUM_ROW_CNT)) ? NUM_ROW_CNT : cmd_num_row;
   assign last_row    = (row_cnt_reg == (num_row_reg - 1'b1));

   assign cmd_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);

   assign sin_ready = (state_reg == LOAD);
   assign load_fire = sin_valid & sin_ready;

   assign move_wenable    = ((state_reg == LOAD) & sin_valid) | (state_reg == PAD);
   assign move_wdata_list = (state_reg == LOAD) ? sin_data : '0;

   // Read only when the output register is empty or being emptied this cycle.
   assign move_renable = (state_reg == UNLOAD) & (row_cnt_reg < num_row_reg) &
                         (~sout_valid_reg | sout_ready);

   assign sout_valid = sout_valid_reg;
   assign sout_data  = sout_data_reg;

   always_ff @(posedge clk) begin
      if (!rstnn) begin
         state_reg      <= IDLE;
         row_cnt_reg    <= '0;
         num_row_reg    <= '0;
         align_reg      <= 1'b0;
         sout_valid_reg <= 1'b0;
         sout_data_reg  <= '0;
      end else begin
         if (move_renable) begin
            sout_valid_reg <= 1'b1;
            sout_data_reg  <= move_rdata_list;
         end else if (sout_ready) begin
            sout_valid_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (cmd_valid) begin
                  num_row_reg <= eff_num_row;
                  align_reg   <= cmd_align;
                  row_cnt_reg <= '0;
                  state_reg   <= cmd_write ? LOAD : UNLOAD;
               end
            end
            LOAD: begin
               if (load_fire) begin
                  row_cnt_reg <= row_cnt_reg + 1'b1;
                  if (last_row) begin
                     state_reg <= (align_reg && (num_row_reg < NUM_ROW_CNT)) ? PAD : DONE;
                  end
               end
            end
            PAD: begin
               // row_cnt continues from N, so PAD lasts NUM_ROW-N cycles.
               row_cnt_reg <= row_cnt_reg + 1'b1;
               if (row_cnt_reg == (NUM_ROW_CNT - 1'b1)) begin
                  state_reg <= DONE;
               end
            end
            UNLOAD: begin
               if (move_renable) begin
                  row_cnt_reg <= row_cnt_reg + 1'b1;
                  if (last_row) begin
                     state_reg <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!sout_valid_reg || sout_ready) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
